// File: rtl/acc_pkg.sv
// Shared types for the accelerator FPU path: fpnew-style command/status types,
// the FPU arbiter state encoding and its default in-flight limit.
package acc_pkg;

   localparam int ACC_FPU_MAX_OUTSTANDING = 4;

   typedef enum logic [3:0] {
      FMADD, FNMSUB, ADD, MUL, DIV, SQRT, SGNJ, MINMAX,
      CMP, CLASSIFY, F2F, F2I, I2F, CPKAB, CPKCD
   } operation_e;

   typedef enum logic [2:0] {
      RNE = 3'b000, RTZ = 3'b001, RDN = 3'b010, RUP = 3'b011, RMM = 3'b100, DYN = 3'b111
   } roundmode_e;

   typedef enum logic [2:0] {FP32, FP64, FP16, FP8, FP16ALT} fp_format_e;

   typedef enum logic [1:0] {INT8, INT16, INT32, INT64} int_format_e;

   typedef struct packed {
      logic nv;
      logic dz;
      logic of;
      logic uf;
      logic nx;
   } status_t;

   typedef struct packed {
      operation_e  op;
      logic        op_mod;
      roundmode_e  rnd_mode;
      fp_format_e  src_fmt;
      fp_format_e  dst_fmt;
      int_format_e int_fmt;
   } fpu_cmd_t;

   typedef enum logic [1:0] {IDLE, ISSUE, FLUSH} arb_state_e;

endpackage

// File: rtl/acc_rr_arbiter.sv
// Combinational round-robin pick: first set bit of valid at or after ptr,
// wrapping modulo NUM_REQ. Reusable for any shared port.
module acc_rr_arbiter #(
   parameter int NUM_REQ = 3,
   parameter int IDX_W   = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] valid,
   input  logic [IDX_W-1:0]   ptr,
   output logic [IDX_W-1:0]   idx,
   output logic               found
);

   int pos;

   always_comb begin
      idx   = '0;
      found = 1'b0;
      pos   = 0;
      for (int k = 0; k < NUM_REQ; k++) begin
         pos = (int'(ptr) + k) % NUM_REQ;
         if (!found && valid[pos]) begin
            found = 1'b1;
            idx   = IDX_W'(pos);
         end
      end
   end

endmodule

// File: rtl/acc_fpu_arbiter.sv
// Shares one FPU between NUM_REQ requesters: round-robin issue, bounded in-flight
// count, tag-routed results, flush/drain. ACC_FPU_ARB_PERF_EN adds perf counters.
module acc_fpu_arbiter
   import acc_pkg::*;
#(
   parameter int NUM_REQ         = 3,
   parameter int MAX_OUTSTANDING = ACC_FPU_MAX_OUTSTANDING,
   parameter int DATA_WIDTH      = 32,
   parameter int TAG_W           = $clog2(NUM_REQ)
) (
   input  logic                                   clk_i,
   input  logic                                   rst_i,
   input  logic [NUM_REQ-1:0]                     req_valid_i,
   output logic [NUM_REQ-1:0]                     req_ready_o,
   input  logic [NUM_REQ-1:0][2:0][DATA_WIDTH-1:0] req_operands_i,
   input  fpu_cmd_t [NUM_REQ-1:0]                 req_cmd_i,
   output logic [NUM_REQ-1:0]                     rsp_valid_o,
   input  logic [NUM_REQ-1:0]                     rsp_ready_i,
   output logic [DATA_WIDTH-1:0]                  rsp_result_o,
   output status_t                                rsp_status_o,
   input  logic                                   flush_i,
   output logic                                   busy_o,
   output logic [2:0][DATA_WIDTH-1:0]             fpu_operands_o,
   output fpu_cmd_t                               fpu_cmd_o,
   output logic [TAG_W-1:0]                       fpu_tag_o,
   output logic                                   fpu_in_valid_o,
   input  logic                                   fpu_in_ready_i,
   output logic                                   fpu_flush_o,
   input  logic [DATA_WIDTH-1:0]                  fpu_result_i,
   input  status_t                                fpu_status_i,
   input  logic [TAG_W-1:0]                       fpu_tag_i,
   input  logic                                   fpu_out_valid_i,
   output logic                                   fpu_out_ready_o,
   input  logic                                   fpu_busy_i
`ifdef ACC_FPU_ARB_PERF_EN
   ,
   output logic [NUM_REQ-1:0][31:0]               perf_issue_o,
   output logic [31:0]                            perf_stall_o
`endif
);

   localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);
   localparam logic [OUT_W-1:0] OUT_MAX = OUT_W'(MAX_OUTSTANDING);

   arb_state_e       state_reg, state_next;
   logic [TAG_W-1:0] grant_reg, grant_next;
   logic [TAG_W-1:0] rr_ptr_reg, rr_ptr_next;
   logic [OUT_W-1:0] outstanding_reg, outstanding_next;
   logic             flush_pulse_reg, flush_pulse_next;
   logic             tag_err_reg;
   logic [TAG_W-1:0] pick_idx;
   logic             pick_found;
   logic             in_flush, in_issue, in_hs, out_hs, tag_ok, rsp_en, retire;

   acc_rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (TAG_W)
   ) u_rr (
      .valid (req_valid_i),
      .ptr   (rr_ptr_reg),
      .idx   (pick_idx),
      .found (pick_found)
   );

   assign in_flush = (state_reg == FLUSH);
   assign in_issue = (state_reg == ISSUE);

   // A flush arriving in the handshake cycle cancels the issue outright.
   assign fpu_in_valid_o = in_issue && !flush_i;
   assign in_hs          = fpu_in_valid_o && fpu_in_ready_i;
   assign fpu_operands_o = in_issue ? req_operands_i[grant_reg] : '0;
   assign fpu_cmd_o      = in_issue ? req_cmd_i[grant_reg] : '0;
   assign fpu_tag_o      = in_issue ? grant_reg : '0;
   assign fpu_flush_o    = flush_pulse_reg;
   assign busy_o         = (outstanding_reg != '0) || (state_reg != IDLE);

   assign tag_ok          = (int'(fpu_tag_i) < NUM_REQ);
   assign rsp_en          = fpu_out_valid_i && !in_flush;
   assign fpu_out_ready_o = in_flush || !tag_ok || rsp_ready_i[fpu_tag_i];
   assign out_hs          = fpu_out_valid_i && fpu_out_ready_o;
   assign retire          = out_hs && !in_flush && (outstanding_reg != '0);
   assign rsp_result_o    = rsp_en ? fpu_result_i : '0;
   assign rsp_status_o    = rsp_en ? fpu_status_i : '0;

   generate
      for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_port
         assign req_ready_o[gi] = in_hs && (grant_reg == TAG_W'(gi));
         assign rsp_valid_o[gi] = rsp_en && (fpu_tag_i == TAG_W'(gi));
      end
   endgenerate

   always_comb begin
      state_next       = state_reg;
      grant_next       = grant_reg;
      rr_ptr_next      = rr_ptr_reg;
      outstanding_next = outstanding_reg;
      flush_pulse_next = 1'b0;

      if (in_hs && !retire)
         outstanding_next = outstanding_reg + 1'b1;
      else if (retire && !in_hs)
         outstanding_next = outstanding_reg - 1'b1;

      case (state_reg)
         IDLE: begin
            // Uses the registered count, so a same-cycle retire frees a slot one cycle later.
            if (pick_found && (outstanding_reg < OUT_MAX)) begin
               grant_next = pick_idx;
               state_next = ISSUE;
            end
         end
         ISSUE: begin
            if (in_hs) begin
               state_next  = IDLE;
               rr_ptr_next = (grant_reg == TAG_W'(NUM_REQ - 1)) ? '0 : grant_reg + 1'b1;
            end
         end
         FLUSH: begin
            if (!flush_i && !fpu_busy_i) begin
               state_next       = IDLE;
               outstanding_next = '0;
            end
         end
         default: state_next = IDLE;
      endcase

      if (flush_i && !in_flush) begin
         state_next       = FLUSH;
         flush_pulse_next = 1'b1;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_reg       <= IDLE;
         grant_reg       <= '0;
         rr_ptr_reg      <= '0;
         outstanding_reg <= '0;
         flush_pulse_reg <= 1'b0;
         tag_err_reg     <= 1'b0;
      end else begin
         state_reg       <= state_next;
         grant_reg       <= grant_next;
         rr_ptr_reg      <= rr_ptr_next;
         outstanding_reg <= outstanding_next;
         flush_pulse_reg <= flush_pulse_next;
         if (rsp_en && !tag_ok)
            tag_err_reg <= 1'b1;
      end
   end

`ifndef SYNTHESIS
   tag_range_a: assert property (@(posedge clk_i) disable iff (rst_i) !tag_err_reg);
`endif

`ifdef ACC_FPU_ARB_PERF_EN
   logic [NUM_REQ-1:0][31:0] perf_issue_reg;
   logic [31:0]              perf_stall_reg;

   // Saturating counters; only reset clears them.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         perf_issue_reg <= '0;
         perf_stall_reg <= '0;
      end else begin
         for (int k = 0; k < NUM_REQ; k++) begin
            if (req_ready_o[k] && (perf_issue_reg[k] != '1))
               perf_issue_reg[k] <= perf_issue_reg[k] + 32'd1;
         end
         if ((|req_valid_i) && !in_hs && (perf_stall_reg != '1))
            perf_stall_reg <= perf_stall_reg + 32'd1;
      end
   end

   assign perf_issue_o = perf_issue_reg;
   assign perf_stall_o = perf_stall_reg;
`endif

endmodule

// File: tb/tb_acc_fpu_arbiter.sv
// Directed bench for acc_fpu_arbiter; the bench itself plays the FPU side.
module tb_acc_fpu_arbiter;
   import acc_pkg::*;

   localparam int NUM_REQ = 3;
   localparam int DW      = 32;
   localparam int TAG_W   = 2;

   logic                               clk_i = 1'b0;
   logic                               rst_i = 1'b1;
   logic [NUM_REQ-1:0]                 req_valid_i;
   logic [NUM_REQ-1:0]                 req_ready_o;
   logic [NUM_REQ-1:0][2:0][DW-1:0]    req_operands_i;
   fpu_cmd_t [NUM_REQ-1:0]             req_cmd_i;
   logic [NUM_REQ-1:0]                 rsp_valid_o;
   logic [NUM_REQ-1:0]                 rsp_ready_i;
   logic [DW-1:0]                      rsp_result_o;
   status_t                            rsp_status_o;
   logic                               flush_i;
   logic                               busy_o;
   logic [2:0][DW-1:0]                 fpu_operands_o;
   fpu_cmd_t                           fpu_cmd_o;
   logic [TAG_W-1:0]                   fpu_tag_o;
   logic                               fpu_in_valid_o;
   logic                               fpu_in_ready_i;
   logic                               fpu_flush_o;
   logic [DW-1:0]                      fpu_result_i;
   status_t                            fpu_status_i;
   logic [TAG_W-1:0]                   fpu_tag_i;
   logic                               fpu_out_valid_i;
   logic                               fpu_out_ready_o;
   logic                               fpu_busy_i;
`ifdef ACC_FPU_ARB_PERF_EN
   logic [NUM_REQ-1:0][31:0]           perf_issue;
   logic [31:0]                        perf_stall;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   acc_fpu_arbiter #(
      .NUM_REQ         (NUM_REQ),
      .MAX_OUTSTANDING (4),
      .DATA_WIDTH      (DW),
      .TAG_W           (TAG_W)
   ) dut (
      .clk_i           (clk_i),
      .rst_i           (rst_i),
      .req_valid_i     (req_valid_i),
      .req_ready_o     (req_ready_o),
      .req_operands_i  (req_operands_i),
      .req_cmd_i       (req_cmd_i),
      .rsp_valid_o     (rsp_valid_o),
      .rsp_ready_i     (rsp_ready_i),
      .rsp_result_o    (rsp_result_o),
      .rsp_status_o    (rsp_status_o),
      .flush_i         (flush_i),
      .busy_o          (busy_o),
      .fpu_operands_o  (fpu_operands_o),
      .fpu_cmd_o       (fpu_cmd_o),
      .fpu_tag_o       (fpu_tag_o),
      .fpu_in_valid_o  (fpu_in_valid_o),
      .fpu_in_ready_i  (fpu_in_ready_i),
      .fpu_flush_o     (fpu_flush_o),
      .fpu_result_i    (fpu_result_i),
      .fpu_status_i    (fpu_status_i),
      .fpu_tag_i       (fpu_tag_i),
      .fpu_out_valid_i (fpu_out_valid_i),
      .fpu_out_ready_o (fpu_out_ready_o),
      .fpu_busy_i      (fpu_busy_i)
`ifdef ACC_FPU_ARB_PERF_EN
      ,
      .perf_issue_o    (perf_issue),
      .perf_stall_o    (perf_stall)
`endif
   );

   always #5 clk_i = ~clk_i;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end else begin
         $display("ok   %s: 0x%0h", tag, got);
      end
   endtask

   initial begin
      int       cnt [NUM_REQ];
      int       n_hs;
      logic     busy_ok;
      fpu_cmd_t c;

      for (int k = 0; k < NUM_REQ; k++) cnt[k] = 0;
      req_valid_i     = '0;
      rsp_ready_i     = '0;
      flush_i         = 1'b0;
      fpu_in_ready_i  = 1'b1;
      fpu_result_i    = '0;
      fpu_status_i    = '0;
      fpu_tag_i       = '0;
      fpu_out_valid_i = 1'b0;
      fpu_busy_i      = 1'b0;
      c.op_mod   = 1'b0;
      c.rnd_mode = RNE;
      c.src_fmt  = FP32;
      c.dst_fmt  = FP32;
      c.int_fmt  = INT32;
      c.op = ADD; req_cmd_i[0] = c;
      c.op = MUL; req_cmd_i[1] = c;
      c.op = DIV; req_cmd_i[2] = c;
      req_operands_i[0] = {32'h40000000, 32'h3F800000, 32'h00000000};
      req_operands_i[1] = {32'h00000003, 32'h00000002, 32'h00000001};
      req_operands_i[2] = {32'h00000006, 32'h00000005, 32'h00000004};

      // Reset state
      #2;
      check_eq("rst_busy", busy_o, 1'b0);
      check_eq("rst_in_valid", fpu_in_valid_o, 1'b0);
      check_eq("rst_req_ready", req_ready_o, 3'b000);
      check_eq("rst_flush", fpu_flush_o, 1'b0);
      check_eq("rst_rsp_valid", rsp_valid_o, 3'b000);
      @(negedge clk_i);
      rst_i = 1'b0;

      // Single requester 0: FADD 1.0 + 2.0
      req_valid_i = 3'b001;
      #1 check_eq("t1_arb_latency", fpu_in_valid_o, 1'b0);
      @(negedge clk_i);
      check_eq("t1_in_valid", fpu_in_valid_o, 1'b1);
      check_eq("t1_tag", fpu_tag_o, 0);
      check_eq("t1_req_ready", req_ready_o, 3'b001);
      check_eq("t1_op_a", fpu_operands_o[1], 32'h3F800000);
      check_eq("t1_op_b", fpu_operands_o[2], 32'h40000000);
      check_eq("t1_cmd", fpu_cmd_o.op, ADD);
      @(negedge clk_i);
      req_valid_i = 3'b000;
      #1 check_eq("t1_busy", busy_o, 1'b1);
      check_eq("t1_idle_valid", fpu_in_valid_o, 1'b0);
      fpu_out_valid_i = 1'b1;
      fpu_tag_i       = 2'd0;
      fpu_result_i    = 32'h40400000;
      rsp_ready_i     = 3'b001;
      #1 check_eq("t1_rsp_valid", rsp_valid_o, 3'b001);
      check_eq("t1_rsp_result", rsp_result_o, 32'h40400000);
      check_eq("t1_out_ready", fpu_out_ready_o, 1'b1);
      @(negedge clk_i);
      fpu_out_valid_i = 1'b0;
      fpu_result_i    = '0;
      #1 check_eq("t1_retired", busy_o, 1'b0);

      // Asynchronous reset while requester 1 sits in ISSUE
      req_valid_i    = 3'b010;
      fpu_in_ready_i = 1'b0;
      @(negedge clk_i);
      check_eq("t6_tag", fpu_tag_o, 1);
      check_eq("t6_in_valid", fpu_in_valid_o, 1'b1);
      #2 rst_i = 1'b1;
      #1 check_eq("t6_async_valid", fpu_in_valid_o, 1'b0);
      check_eq("t6_async_tag", fpu_tag_o, 0);
      check_eq("t6_async_busy", busy_o, 1'b0);
      check_eq("t6_async_ops", fpu_operands_o[0], 32'h0);
      @(negedge clk_i);
      rst_i          = 1'b0;
      req_valid_i    = 3'b111;
      fpu_in_ready_i = 1'b1;

      // All three valid continuously: grants 0,1,2,0,1,2 from a cleared pointer
      for (int i = 0; i < 6; i++) begin
         @(negedge clk_i);
         fpu_out_valid_i = 1'b0;
         #1 check_eq("t2_tag", fpu_tag_o, i % 3);
         check_eq("t2_req_ready", req_ready_o, 64'd1 << (i % 3));
         for (int k = 0; k < NUM_REQ; k++) cnt[k] += int'(req_ready_o[k]);
         @(negedge clk_i);
         fpu_out_valid_i = 1'b1;
         fpu_tag_i       = TAG_W'(i % 3);
         rsp_ready_i     = 3'b111;
         if (i == 5) req_valid_i = 3'b000;
      end
      @(negedge clk_i);
      fpu_out_valid_i = 1'b0;
      #1 check_eq("t2_idle", busy_o, 1'b0);
      for (int k = 0; k < NUM_REQ; k++) check_eq("t2_share", cnt[k], 2);

      // Outstanding limit: five ops with results held back
      rsp_ready_i = 3'b001;
      fpu_tag_i   = 2'd0;
      req_valid_i = 3'b001;
      n_hs        = 0;
      busy_ok     = 1'b1;
      repeat (14) begin
         @(negedge clk_i);
         #1;
         n_hs += int'(req_ready_o[0]);
         if (!busy_o) busy_ok = 1'b0;
      end
      check_eq("t3_issued", n_hs, 4);
      check_eq("t3_busy", busy_ok, 1'b1);
      check_eq("t3_fifth_held", fpu_in_valid_o, 1'b0);
      fpu_out_valid_i = 1'b1;
      #1 check_eq("t3_rsp_valid", rsp_valid_o, 3'b001);
      @(negedge clk_i);
      fpu_out_valid_i = 1'b0;
      #1 check_eq("t3_slot_next_cycle", fpu_in_valid_o, 1'b0);
      @(negedge clk_i);
      check_eq("t3_fifth_valid", fpu_in_valid_o, 1'b1);
      check_eq("t3_fifth_ready", req_ready_o, 3'b001);
      req_valid_i     = 3'b000;
      fpu_out_valid_i = 1'b1;
      repeat (3) @(negedge clk_i);
      #1 check_eq("t3_one_left", busy_o, 1'b1);
      @(negedge clk_i);
      fpu_out_valid_i = 1'b0;
      #1 check_eq("t3_drained", busy_o, 1'b0);

      // Tag 2 result back-pressured by its requester
      req_valid_i = 3'b100;
      @(negedge clk_i);
      check_eq("t4_tag", fpu_tag_o, 2);
      req_valid_i = 3'b000;
      @(negedge clk_i);
      fpu_out_valid_i = 1'b1;
      fpu_tag_i       = 2'd2;
      fpu_result_i    = 32'hC0000000;
      rsp_ready_i     = 3'b011;
      #1 check_eq("t4_out_ready_low", fpu_out_ready_o, 1'b0);
      check_eq("t4_rsp_valid", rsp_valid_o, 3'b100);
      check_eq("t4_result", rsp_result_o, 32'hC0000000);
      @(negedge clk_i);
      check_eq("t4_held_busy", busy_o, 1'b1);
      rsp_ready_i = 3'b111;
      #1 check_eq("t4_out_ready_high", fpu_out_ready_o, 1'b1);
      @(negedge clk_i);
      fpu_out_valid_i = 1'b0;
      fpu_result_i    = '0;
      #1 check_eq("t4_retired", busy_o, 1'b0);

      // Flush with three in flight and a fourth op presented
      req_valid_i    = 3'b001;
      fpu_in_ready_i = 1'b1;
      fpu_tag_i      = 2'd0;
      rsp_ready_i    = 3'b000;
      repeat (6) @(negedge clk_i);
      fpu_in_ready_i = 1'b0;
      @(negedge clk_i);
      check_eq("t5_in_valid", fpu_in_valid_o, 1'b1);
      flush_i        = 1'b1;
      fpu_in_ready_i = 1'b1;
      fpu_busy_i     = 1'b1;
      #1 check_eq("t5_flush_wins", req_ready_o, 3'b000);
      @(negedge clk_i);
      flush_i         = 1'b0;
      fpu_out_valid_i = 1'b1;
      #1 check_eq("t5_flush_pulse", fpu_flush_o, 1'b1);
      check_eq("t5_no_ready", req_ready_o, 3'b000);
      check_eq("t5_rsp_blocked", rsp_valid_o, 3'b000);
      check_eq("t5_discard", fpu_out_ready_o, 1'b1);
      @(negedge clk_i);
      fpu_out_valid_i = 1'b0;
      #1 check_eq("t5_pulse_single", fpu_flush_o, 1'b0);
      check_eq("t5_drain_busy", busy_o, 1'b1);
      check_eq("t5_drain_no_issue", fpu_in_valid_o, 1'b0);
      fpu_busy_i = 1'b0;
      @(negedge clk_i);
      req_valid_i = 3'b000;
      #1 check_eq("t5_idle_zero", busy_o, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
